countdown_timer: RTL and testbench

//   Loadable, programmable down-counter timer: counts a preset value down to zero on external tick pulses.

---
 rtl/countdown_timer_pkg.sv | 19 +
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer_dcount_core.sv | 47 ++++
 rtl/countdown_timer.sv | 101 ++++++++++
 tb/tb_countdown_timer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ==== countdown_timer_pkg : shared state encodings for timer blocks (rev 1.0) ====
package countdown_timer_pkg;

   localparam int N_DEFAULT = 7;

   // 2'd3 is unused and decodes back to IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic logic is_busy_state(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ==== countdown_timer_if : control/status bundle of the countdown timer (rev 1.0) ====
interface countdown_timer_if #(
   parameter int N = 7
) ();

   logic         load;
   logic [N-1:0] load_val;
   logic         start;
   logic         pause;
   logic         tick;
   logic         auto_reload;
   logic [N-1:0] q;
   logic         busy;
   logic         done;

   modport master (
      output load, load_val, start, pause, tick, auto_reload,
      input  q, busy, done
   );

   modport slave (
      input  load, load_val, start, pause, tick, auto_reload,
      output q, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/countdown_timer_dcount_core.sv
`default_nettype none
// ==== dcount_core : preset + count registers with load/reload/clear/decrement (rev 1.0) ====
module dcount_core #(
   parameter int N = 7
) (
   input  wire logic         clk,
   input  wire logic         arst,
   input  wire logic         load,
   input  wire logic [N-1:0] load_val,
   input  wire logic         reload,
   input  wire logic         clear,
   input  wire logic         dec,
   output logic      [N-1:0] q,
   output logic              q_zero,
   output logic              q_one,
   output logic              preset_zero
);

   localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] r_preset;
   logic [N-1:0] r_q;

   always_ff @(posedge clk) begin
      if (arst) begin
         r_preset <= '0;
         r_q      <= '0;
      end else if (load) begin
         r_preset <= load_val;
         r_q      <= load_val;
      end else if (reload) begin
         r_q <= r_preset;
      end else if (clear) begin
         r_q <= '0;
      end else if (dec && (r_q != '0)) begin
         // floor at zero: never wraps to all-ones
         r_q <= r_q - C_ONE;
      end
   end

   assign q           = r_q;
   assign q_zero      = (r_q == '0);
   assign q_one       = (r_q == C_ONE);
   assign preset_zero = (r_preset == '0);

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ==== countdown_timer : loadable down-counter with expiry pulse and auto-reload (rev 1.0) ====
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input wire logic         clk,
   input wire logic         arst,
   countdown_timer_if.slave bus
);

   state_t       r_state;
   state_t       w_state_n;
   logic         r_done;
   logic         w_done_n;
   logic         r_busy;
   logic         w_reload;
   logic         w_clear;
   logic         w_dec;
   logic [N-1:0] w_q;
   logic         w_q_zero;
   logic         w_q_one;
   logic         w_preset_zero;

   dcount_core #(.N(N)) u_core (
      .clk         (clk),
      .arst        (arst),
      .load        (bus.load),
      .load_val    (bus.load_val),
      .reload      (w_reload),
      .clear       (w_clear),
      .dec         (w_dec),
      .q           (w_q),
      .q_zero      (w_q_zero),
      .q_one       (w_q_one),
      .preset_zero (w_preset_zero)
   );

   always_ff @(posedge clk) begin
      if (arst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_done  <= w_done_n;
         r_busy  <= is_busy_state(w_state_n);
      end
   end

   // Priority: load > start > pause > tick; start is only meaningful in IDLE
   always_comb begin
      w_state_n = r_state;
      w_done_n  = 1'b0;
      w_reload  = 1'b0;
      w_clear   = 1'b0;
      w_dec     = 1'b0;
      if (bus.load) begin
         w_state_n = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (w_q_zero) w_done_n  = 1'b1;
                  else          w_state_n = ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.pause) begin
                  w_state_n = ST_HOLD;
               end else if (w_q_zero) begin
                  w_state_n = ST_IDLE;
               end else if (bus.tick) begin
                  if (w_q_one) begin
                     w_done_n = 1'b1;
                     if (bus.auto_reload && !w_preset_zero) begin
                        w_reload = 1'b1;
                     end else begin
                        w_clear   = 1'b1;
                        w_state_n = ST_IDLE;
                     end
                  end else begin
                     w_dec = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (!bus.pause) w_state_n = ST_RUN;
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   assign bus.q    = w_q;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ==== tb_countdown_timer : scoreboard bench with behavioural timer model (rev 1.0) ====
module tb_countdown_timer;

   localparam int N = 7;

   typedef struct packed {
      logic [N-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   logic clk = 1'b0;
   logic arst;
   int   compared   = 0;
   int   mismatched = 0;
   int   cycle_no   = 0;
   exp_t sb[$];

   // behavioural model: plain integers and flags
   int m_q, m_pre;
   bit m_active, m_paused, m_done;

   countdown_timer_if #(.N(N)) ifc ();

   countdown_timer #(.N(N)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic model_step(input bit a, ld, input int lv, input bit st, pa, tk, ar);
      m_done = 1'b0;
      if (a) begin
         m_q = 0; m_pre = 0; m_active = 0; m_paused = 0;
      end else if (ld) begin
         m_q = lv; m_pre = lv; m_active = 0; m_paused = 0;
      end else if (!m_active) begin
         if (st) begin
            if (m_q == 0) m_done = 1'b1;
            else          m_active = 1'b1;
         end
      end else if (m_paused) begin
         if (!pa) m_paused = 1'b0;
      end else if (pa) begin
         m_paused = 1'b1;
      end else if (tk) begin
         if (m_q == 1) begin
            m_done = 1'b1;
            if (ar && m_pre != 0) m_q = m_pre;
            else begin
               m_q = 0; m_active = 0;
            end
         end else if (m_q > 0) begin
            m_q = m_q - 1;
         end
      end
   endtask

   task automatic cyc(input bit a, ld, input int lv, input bit st, pa, tk, ar);
      exp_t e;
      logic [31:0] lvv;
      @(negedge clk);
      lvv             = lv;
      arst            = a;
      ifc.load        = ld;
      ifc.load_val    = lvv[N-1:0];
      ifc.start       = st;
      ifc.pause       = pa;
      ifc.tick        = tk;
      ifc.auto_reload = ar;
      model_step(a, ld, int'(lvv[N-1:0]), st, pa, tk, ar);
      e.q    = m_q[N-1:0];
      e.busy = m_active;
      e.done = m_done;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n, input bit ar);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1, ar);
   endtask

   // monitor: outputs are valid every cycle after the edge that consumed the stimulus
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle_no++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (ifc.q !== e.q || ifc.busy !== e.busy || ifc.done !== e.done) begin
               mismatched++;
               $display("FAIL scoreboard cycle %0d: got q=%0d busy=%b done=%b, expected q=%0d busy=%b done=%b",
                        cycle_no, ifc.q, ifc.busy, ifc.done, e.q, e.busy, e.done);
            end
         end
      end
   end

   initial begin
      int lv;
      bit a, ld, st, pa, tk, ar;
      arst = 1'b1;
      ifc.load = 0; ifc.load_val = '0; ifc.start = 0;
      ifc.pause = 0; ifc.tick = 0; ifc.auto_reload = 0;
      m_q = 0; m_pre = 0; m_active = 0; m_paused = 0; m_done = 0;

      // reset values
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 1);
      idle(1);

      // reset mid-count, then ticks ignored until start
      cyc(0, 1, 40, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      ticks(3, 0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      ticks(3, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);

      // simple countdown to expiry
      cyc(0, 1, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      ticks(5, 0);
      ticks(2, 0);

      // auto-reload periodic run
      cyc(0, 1, 3, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 0, 1);
      ticks(7, 1);
      cyc(0, 1, 1, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 0, 1);
      ticks(4, 1);

      // pause with ticks held high
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      ticks(1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      ticks(3, 0);

      // load aborts a run; start with q==0 gives a lone done
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      ticks(2, 0);
      cyc(0, 1, 6, 0, 0, 1, 0);
      ticks(2, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 1, 0, 0, 1);

      // full-range count, then extra ticks must not wrap
      cyc(0, 1, 127, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      ticks(130, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         a  = ($urandom_range(0, 399) == 0);
         ld = ($urandom_range(0, 29) == 0);
         lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
         st = ($urandom_range(0, 5) == 0);
         pa = ($urandom_range(0, 7) == 0);
         tk = ($urandom_range(0, 1) == 1);
         ar = ($urandom_range(0, 1) == 1);
         cyc(a, ld, lv, st, pa, tk, ar);
      end

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
